// File: rtl/load_store_unit.sv
// load_store_unit: memory stage; accepts an execute result, performs a
// byte/half/word/dword access over a req/ack RAM port, hands result on.
// Ports: execute side  in_valid/in_ready, addr, data_in, MemRead, MemWrite,
//        funct3, in_side; writeback side out_valid/out_ready, data_out,
//        out_side, misaligned, bus_error; RAM side mem_req, mem_write_enable,
//        mem_addr, mem_write_data, mem_byte_en, mem_ack, mem_read_data.
//        rst is synchronous, active-low.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int SIDE_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   data_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   data_out,
  output logic [SIDE_W-1:0] out_side,
  output logic              misaligned,
  output logic              bus_error,
  output logic              mem_req,
  output logic              mem_write_enable,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_write_data,
  output logic [XLEN/8-1:0] mem_byte_en,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_read_data
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OP_PASS, OP_LOAD, OP_STORE} op_t;

  state_t            state, stateN;
  op_t               opQ, opN, inOp;
  logic [XLEN-1:0]   addrQ, addrN;
  logic [XLEN-1:0]   dataQ, dataN;
  logic [XLEN-1:0]   outQ, outN;
  logic [2:0]        f3Q, f3N;
  logic [SIDE_W-1:0] sideQ, sideN;
  logic              misQ, misN;
  logic              berrQ, berrN;
  logic [TW-1:0]     cntQ, cntN;

  logic              bad;
  logic              inAcc;
  logic [OW-1:0]     offs;
  logic [NB-1:0]     szMask;
  logic [XLEN-1:0]   wData;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   loadVal;

  // Store wins when both MemWrite and MemRead are set.
  always_comb begin
    inOp = OP_PASS;
    if (MemWrite)
      inOp = OP_STORE;
    else if (MemRead)
      inOp = OP_LOAD;
  end

  // Alignment / legality of the offered access, judged at accept time.
  always_comb begin
    bad = 1'b0;
    unique case (funct3[1:0])
      2'd1:    bad = addr[0];
      2'd2:    bad = |addr[1:0];
      2'd3:    bad = (|addr[2:0]) || (XLEN == 32);
      default: bad = 1'b0;
    endcase
    if (funct3 == 3'b111)
      bad = 1'b1;
    if ((funct3 == 3'b110) && (XLEN == 32))
      bad = 1'b1;
  end

  assign offs  = addrQ[OW-1:0];
  assign inAcc = (state == ACCESS);

  always_comb begin
    szMask = '1;
    wData  = dataQ;
    unique case (f3Q[1:0])
      2'd0: begin
        szMask = NB'(1);
        wData  = {NB{dataQ[7:0]}};
      end
      2'd1: begin
        szMask = NB'(3);
        wData  = {(NB/2){dataQ[15:0]}};
      end
      2'd2: begin
        szMask = NB'(15);
        wData  = {(XLEN/32){dataQ[31:0]}};
      end
      default: begin
        szMask = '1;
        wData  = dataQ;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by size/sign.
  assign shifted = mem_read_data >> {offs, 3'b000};

  always_comb begin
    loadVal = shifted;
    unique case (f3Q[1:0])
      2'd0: loadVal = f3Q[2] ? XLEN'(shifted[7:0])
                             : XLEN'($signed(shifted[7:0]));
      2'd1: loadVal = f3Q[2] ? XLEN'(shifted[15:0])
                             : XLEN'($signed(shifted[15:0]));
      2'd2: loadVal = f3Q[2] ? XLEN'(shifted[31:0])
                             : XLEN'($signed(shifted[31:0]));
      default: loadVal = shifted;
    endcase
  end

  always_comb begin
    stateN = state;
    opN    = opQ;
    addrN  = addrQ;
    dataN  = dataQ;
    f3N    = f3Q;
    sideN  = sideQ;
    outN   = outQ;
    misN   = misQ;
    berrN  = berrQ;
    cntN   = cntQ;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          opN   = inOp;
          addrN = addr;
          dataN = data_in;
          f3N   = funct3;
          sideN = in_side;
          cntN  = '0;
          misN  = 1'b0;
          berrN = 1'b0;
          outN  = '0;
          if (inOp == OP_PASS) begin
            outN   = addr;
            stateN = RESP;
          end else if (bad) begin
            misN   = 1'b1;
            stateN = RESP;
          end else begin
            stateN = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack on the final allowed cycle still completes normally.
        if (mem_ack) begin
          outN   = (opQ == OP_LOAD) ? loadVal : '0;
          stateN = RESP;
        end else if ((TIMEOUT > 0) && (cntQ == TW'(TIMEOUT - 1))) begin
          berrN  = 1'b1;
          outN   = '0;
          stateN = RESP;
        end else begin
          cntN = cntQ + TW'(1);
        end
      end
      RESP: begin
        if (out_ready) begin
          stateN = IDLE;
          misN   = 1'b0;
          berrN  = 1'b0;
          outN   = '0;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      opQ   <= OP_PASS;
      addrQ <= '0;
      dataQ <= '0;
      f3Q   <= '0;
      sideQ <= '0;
      outQ  <= '0;
      misQ  <= 1'b0;
      berrQ <= 1'b0;
      cntQ  <= '0;
    end else begin
      state <= stateN;
      opQ   <= opN;
      addrQ <= addrN;
      dataQ <= dataN;
      f3Q   <= f3N;
      sideQ <= sideN;
      outQ  <= outN;
      misQ  <= misN;
      berrQ <= berrN;
      cntQ  <= cntN;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == RESP);
  assign data_out   = outQ;
  assign out_side   = sideQ;
  assign misaligned = misQ;
  assign bus_error  = berrQ;

  assign mem_req          = inAcc;
  assign mem_write_enable = inAcc && (opQ == OP_STORE);
  assign mem_addr         = inAcc ? {addrQ[XLEN-1:OW], {OW{1'b0}}} : '0;
  assign mem_write_data   = (inAcc && (opQ == OP_STORE)) ? wData : '0;
  assign mem_byte_en      = inAcc ? (szMask << offs) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit, one 32-bit
// instance (TIMEOUT=4) and one 64-bit instance sharing stimulus.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        sel64 = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic        memAck = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] dataIn = '0;
  logic [63:0] rdata = '0;
  logic [2:0]  f3 = '0;
  logic [8:0]  side = '0;

  logic        ir32, ov32, mis32, be32f, mr32, we32;
  logic [31:0] do32, ma32, wd32;
  logic [3:0]  be32;
  logic [8:0]  os32;
  logic        ir64, ov64, mis64, be64f, mr64, we64;
  logic [63:0] do64, ma64, wd64;
  logic [7:0]  be64;
  logic [8:0]  os64;

  logic        iReady, oValid, oMis, oBerr, mReq, mWe;
  logic [63:0] dOut, mAddr, mWd;
  logic [7:0]  mBe;
  logic [8:0]  oSide;

  load_store_unit #(.XLEN(32), .SIDE_W(9), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(inValid & ~sel64), .in_ready(ir32),
    .addr(addr[31:0]), .data_in(dataIn[31:0]),
    .MemRead(memRead), .MemWrite(memWrite),
    .funct3(f3), .in_side(side),
    .out_valid(ov32), .out_ready(outReady & ~sel64),
    .data_out(do32), .out_side(os32),
    .misaligned(mis32), .bus_error(be32f),
    .mem_req(mr32), .mem_write_enable(we32),
    .mem_addr(ma32), .mem_write_data(wd32),
    .mem_byte_en(be32), .mem_ack(memAck & ~sel64),
    .mem_read_data(rdata[31:0])
  );

  load_store_unit #(.XLEN(64), .SIDE_W(9), .TIMEOUT(16)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(inValid & sel64), .in_ready(ir64),
    .addr(addr), .data_in(dataIn),
    .MemRead(memRead), .MemWrite(memWrite),
    .funct3(f3), .in_side(side),
    .out_valid(ov64), .out_ready(outReady & sel64),
    .data_out(do64), .out_side(os64),
    .misaligned(mis64), .bus_error(be64f),
    .mem_req(mr64), .mem_write_enable(we64),
    .mem_addr(ma64), .mem_write_data(wd64),
    .mem_byte_en(be64), .mem_ack(memAck & sel64),
    .mem_read_data(rdata)
  );

  always_comb begin
    iReady = sel64 ? ir64 : ir32;
    oValid = sel64 ? ov64 : ov32;
    oMis   = sel64 ? mis64 : mis32;
    oBerr  = sel64 ? be64f : be32f;
    mReq   = sel64 ? mr64 : mr32;
    mWe    = sel64 ? we64 : we32;
    dOut   = sel64 ? do64 : {32'b0, do32};
    mAddr  = sel64 ? ma64 : {32'b0, ma32};
    mWd    = sel64 ? wd64 : {32'b0, wd32};
    mBe    = sel64 ? be64 : {4'b0, be32};
    oSide  = sel64 ? os64 : os32;
  end

  typedef struct {
    logic [63:0] data;
    logic [8:0]  side;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input string tag, input bit w, input bit rd,
                       input bit wr, input logic [63:0] a,
                       input logic [63:0] d, input logic [2:0] fn,
                       input logic [8:0] sd, input bit push,
                       input logic [63:0] expData, input bit expMis,
                       input bit expBerr);
    exp_t e;
    sel64    = w;
    memRead  = rd;
    memWrite = wr;
    addr     = a;
    dataIn   = d;
    f3       = fn;
    side     = sd;
    inValid  = 1'b1;
    #1;
    chk({tag, "_inready"}, 64'(iReady), 64'd1);
    if (push) begin
      e.data = expData;
      e.side = sd;
      e.mis  = expMis;
      e.berr = expBerr;
      sb.push_back(e);
    end
    tick();
    inValid  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic memServe(input string tag, input int waits,
                          input logic [63:0] rd, input logic [7:0] expBe,
                          input bit expWe, input logic [63:0] expAddr,
                          input logic [63:0] expWd, input int expReq);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mReq) break;
      n++;
      chk({tag, "_be"}, 64'(mBe), 64'(expBe));
      chk({tag, "_we"}, 64'(mWe), 64'(expWe));
      chk({tag, "_maddr"}, mAddr, expAddr);
      if (expWe)
        chk({tag, "_wdata"}, mWd, expWd);
      memAck = (i == waits);
      rdata  = rd;
      tick();
      memAck = 1'b0;
    end
    chk({tag, "_reqcycles"}, 64'(n), 64'(expReq));
  endtask

  task automatic collect(input string tag, input int expLat);
    exp_t e;
    int lat = 0;
    while (!oValid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_valid"}, 64'(oValid), 64'd1);
    if (expLat >= 0)
      chk({tag, "_latency"}, 64'(lat), 64'(expLat));
    chk({tag, "_sbnonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, dOut, e.data);
      chk({tag, "_side"}, 64'(oSide), 64'(e.side));
      chk({tag, "_mis"}, 64'(oMis), 64'(e.mis));
      chk({tag, "_berr"}, 64'(oBerr), 64'(e.berr));
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk({tag, "_idle"}, 64'(iReady), 64'd1);
    chk({tag, "_validoff"}, 64'(oValid), 64'd0);
    chk({tag, "_flagsclr"}, 64'({oMis, oBerr}), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    chk("rst_inready", 64'(iReady), 64'd1);
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_req", 64'(mReq), 64'd0);
    chk("rst_data", dOut, 64'd0);
    chk("rst_flags", 64'({oMis, oBerr}), 64'd0);
    chk("rst_be", 64'(mBe), 64'd0);
    chk("rst_side", 64'(oSide), 64'd0);
    rst = 1'b1;
    tick();

    drive("sw", 1'b0, 1'b0, 1'b1, 64'h100, 64'hDEADBEEF, 3'b010,
          9'h011, 1'b1, 64'd0, 1'b0, 1'b0);
    memServe("sw", 3, 64'd0, 8'h0F, 1'b1, 64'h100, 64'hDEADBEEF, 4);
    collect("sw", 0);

    drive("lb", 1'b0, 1'b1, 1'b0, 64'h103, 64'd0, 3'b000,
          9'h022, 1'b1, 64'hFFFFFF80, 1'b0, 1'b0);
    memServe("lb", 0, 64'h80FF0000, 8'h08, 1'b0, 64'h100, 64'd0, 1);
    collect("lb", 0);

    drive("lbu", 1'b0, 1'b1, 1'b0, 64'h103, 64'd0, 3'b100,
          9'h033, 1'b1, 64'h00000080, 1'b0, 1'b0);
    memServe("lbu", 1, 64'h80FF0000, 8'h08, 1'b0, 64'h100, 64'd0, 2);
    collect("lbu", 0);

    drive("sh", 1'b0, 1'b0, 1'b1, 64'h102, 64'h1234, 3'b001,
          9'h044, 1'b1, 64'd0, 1'b0, 1'b0);
    memServe("sh", 0, 64'd0, 8'h0C, 1'b1, 64'h100, 64'h12341234, 1);
    collect("sh", 0);

    drive("lh_mis", 1'b0, 1'b1, 1'b0, 64'h101, 64'd0, 3'b001,
          9'h055, 1'b1, 64'd0, 1'b1, 1'b0);
    memServe("lh_mis", 0, 64'd0, 8'h00, 1'b0, 64'd0, 64'd0, 0);
    collect("lh_mis", 0);

    drive("lwu32", 1'b0, 1'b1, 1'b0, 64'h0, 64'd0, 3'b110,
          9'h066, 1'b1, 64'd0, 1'b1, 1'b0);
    memServe("lwu32", 0, 64'd0, 8'h00, 1'b0, 64'd0, 64'd0, 0);
    collect("lwu32", 0);

    drive("lw_to", 1'b0, 1'b1, 1'b0, 64'h200, 64'd0, 3'b010,
          9'h077, 1'b1, 64'd0, 1'b0, 1'b1);
    memServe("lw_to", 99, 64'hFFFFFFFF, 8'h0F, 1'b0, 64'h200, 64'd0, 4);
    collect("lw_to", 0);

    drive("pass", 1'b0, 1'b0, 1'b0, 64'h55, 64'd0, 3'b000,
          9'h1A5, 1'b1, 64'h55, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("pass_hold_valid", 64'(oValid), 64'd1);
      chk("pass_hold_inready", 64'(iReady), 64'd0);
      chk("pass_hold_data", dOut, 64'h55);
      chk("pass_hold_side", 64'(oSide), 64'h1A5);
      tick();
    end
    collect("pass", 0);

    drive("rstmid", 1'b0, 1'b1, 1'b0, 64'h300, 64'd0, 3'b010,
          9'h088, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("rstmid_req_before", 64'(mReq), 64'd1);
    rst = 1'b0;
    tick();
    chk("rstmid_req_after", 64'(mReq), 64'd0);
    rst    = 1'b1;
    memAck = 1'b1;
    rdata  = 64'h12345678;
    tick();
    memAck = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rstmid_novalid", 64'(oValid), 64'd0);
      chk("rstmid_noreq", 64'(mReq), 64'd0);
      tick();
    end
    chk("rstmid_idle", 64'(iReady), 64'd1);

    drive("ld64", 1'b1, 1'b1, 1'b0, 64'h8, 64'd0, 3'b011,
          9'h099, 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
    memServe("ld64", 1, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 64'h8,
             64'd0, 2);
    collect("ld64", 0);

    drive("lw64", 1'b1, 1'b1, 1'b0, 64'hC, 64'd0, 3'b010,
          9'h0AA, 1'b1, 64'hFFFFFFFF80000000, 1'b0, 1'b0);
    memServe("lw64", 0, 64'h80000000_00000000, 8'hF0, 1'b0, 64'h8,
             64'd0, 1);
    collect("lw64", 0);

    drive("lwu64", 1'b1, 1'b1, 1'b0, 64'h4, 64'd0, 3'b110,
          9'h0BB, 1'b1, 64'h0000000090000000, 1'b0, 1'b0);
    memServe("lwu64", 0, 64'h90000000_00000000, 8'hF0, 1'b0, 64'h0,
             64'd0, 1);
    collect("lwu64", 0);

    drive("sb64", 1'b1, 1'b0, 1'b1, 64'h5, 64'hAB, 3'b000,
          9'h0CC, 1'b1, 64'd0, 1'b0, 1'b0);
    memServe("sb64", 2, 64'd0, 8'h20, 1'b1, 64'h0,
             64'hABABABABABABABAB, 3);
    collect("sb64", 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
